a2bus_write_capture: RTL and testbench

Downstream consumer of the Apple II bus interface. It snoops every completed bus cycle, indicated by the one-cycle data-in strobe, and filters it against a configurable address window. Qualifying cycles are queued as {addr, data, rw_n} entries in a first-word-fall-through FIFO. Soft-switch, mockingboard and other card-emulation logic drain the FIFO through a valid/ready handshake, so they never have to catch single-cycle strobes themselves.

---
 rtl/a2bus_write_capture.sv | 75 +++++++
 tb/tb_a2bus_write_capture.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/a2bus_write_capture.sv
// a2bus_write_capture: snoops completed Apple II bus cycles, keeps those inside an
// address window and queues them as {addr, data, rw_n} in a first-word-fall-through FIFO.
//   clk_logic, reset          : clock and synchronous active-high reset
//   addr_i, data_i, rw_n_i    : latched bus cycle, valid while data_in_strobe_i is high
//   data_in_strobe_i          : one-cycle completion pulse
//   enable_i                  : capture enable
//   m_valid_o/m_ready_i       : head handshake; m_addr_o, m_data_o, m_rw_n_o hold the head entry
//   count_o                   : occupied entries
//   overflow_o, drop_count_o  : sticky drop flag and saturating drop counter
//   clear_overflow_i          : clears overflow_o and drop_count_o
module a2bus_write_capture #(
  parameter int          DEPTH         = 16,
  parameter logic [15:0] ADDR_LO       = 16'hC000,
  parameter logic [15:0] ADDR_HI       = 16'hC0FF,
  parameter bit          CAPTURE_READS = 1'b0
) (
  input  logic                       clk_logic,
  input  logic                       reset,
  input  logic [15:0]                addr_i,
  input  logic [7:0]                 data_i,
  input  logic                       rw_n_i,
  input  logic                       data_in_strobe_i,
  input  logic                       enable_i,
  output logic                       m_valid_o,
  input  logic                       m_ready_i,
  output logic [15:0]                m_addr_o,
  output logic [7:0]                 m_data_o,
  output logic                       m_rw_n_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       overflow_o,
  output logic [7:0]                 drop_count_o,
  input  logic                       clear_overflow_i
);
  localparam int AW = $clog2(DEPTH);
  logic [24:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, next_rd;
  logic [AW:0]   count, count_next;
  logic [24:0]   wr_entry, head_next;
  logic          in_window, push_req, pop, full, push, drop;
  assign in_window  = addr_i >= ADDR_LO && addr_i <= ADDR_HI;
  assign push_req   = data_in_strobe_i & enable_i & in_window & (~rw_n_i | CAPTURE_READS);
  assign pop        = m_valid_o & m_ready_i;
  assign full       = count == (AW+1)'(DEPTH);
  assign push       = push_req & (~full | pop);
  assign drop       = push_req & full & ~pop;
  assign wr_entry   = {addr_i, data_i, rw_n_i};
  assign next_rd    = rd_ptr + AW'(pop);
  assign count_next = count + (AW+1)'(push) - (AW+1)'(pop);
  // The incoming entry becomes the head directly when it lands in the slot the
  // read pointer moves to (empty FIFO, or single entry popped while pushing).
  assign head_next  = (push && wr_ptr == next_rd) ? wr_entry : mem[next_rd];
  assign m_valid_o  = |count;
  assign count_o    = count;
  always_ff @(posedge clk_logic)
    if (push) mem[wr_ptr] <= wr_entry;
  always_ff @(posedge clk_logic) begin
    if (reset) begin
      wr_ptr                         <= '0;
      rd_ptr                         <= '0;
      count                          <= '0;
      {m_addr_o, m_data_o, m_rw_n_o} <= 25'h1;
      overflow_o                     <= 1'b0;
      drop_count_o                   <= 8'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr <= next_rd;
      count  <= count_next;
      if (|count_next) {m_addr_o, m_data_o, m_rw_n_o} <= head_next;
      overflow_o <= drop | (overflow_o & ~clear_overflow_i);
      // A drop coinciding with a clear restarts the count at one.
      drop_count_o <= drop ? (clear_overflow_i ? 8'd1 : (drop_count_o == 8'hFF ? 8'hFF : drop_count_o + 8'd1))
                           : (clear_overflow_i ? 8'd0 : drop_count_o);
    end
  end
endmodule

// File: tb/tb_a2bus_write_capture.sv
// tb_a2bus_write_capture: directed scenarios plus randomized traffic against a queue model.
module tb_a2bus_write_capture;
  logic        clk = 0, rst = 0;
  logic [15:0] addr = 0;
  logic [7:0]  data = 0;
  logic        rw_n = 1, strobe = 0, en = 1, ready = 0, clr = 0;
  logic        m_valid, m_rw_n, ovf;
  logic [15:0] m_addr;
  logic [7:0]  m_data, drops;
  logic [4:0]  count;
  int n_tests = 0, n_fail = 0;
  logic [24:0] q[$];
  bit          mdl_ovf;
  int          mdl_drops;
  a2bus_write_capture dut (
    .clk_logic(clk), .reset(rst), .addr_i(addr), .data_i(data), .rw_n_i(rw_n),
    .data_in_strobe_i(strobe), .enable_i(en), .m_valid_o(m_valid), .m_ready_i(ready),
    .m_addr_o(m_addr), .m_data_o(m_data), .m_rw_n_o(m_rw_n), .count_o(count),
    .overflow_o(ovf), .drop_count_o(drops), .clear_overflow_i(clr)
  );
  always #5 clk = ~clk;
  task automatic cyc();
    bit preq, mpop, was_full;
    @(posedge clk);
    if (rst) begin
      q.delete();
      mdl_ovf   = 0;
      mdl_drops = 0;
    end else begin
      preq     = strobe && en && addr >= 16'hC000 && addr <= 16'hC0FF && !rw_n;
      mpop     = q.size() > 0 && ready;
      was_full = q.size() == 16;
      if (mpop) void'(q.pop_front());
      if (preq && (!was_full || mpop)) q.push_back({addr, data, rw_n});
      if (preq && was_full && !mpop) begin
        mdl_ovf   = 1;
        mdl_drops = clr ? 1 : (mdl_drops >= 255 ? 255 : mdl_drops + 1);
      end else if (clr) begin
        mdl_ovf   = 0;
        mdl_drops = 0;
      end
    end
    #1;
  endtask
  task automatic wr(input logic [15:0] a, input logic [7:0] d, input logic r);
    addr = a; data = d; rw_n = r; strobe = 1;
    cyc();
    strobe = 0;
  endtask
  task automatic drain();
    strobe = 0; ready = 1;
    for (int i = 0; i < 20; i++) cyc();
    ready = 0;
  endtask
  task automatic test_reset();
    rst = 1; cyc(); rst = 0;
    n_tests++; if ({m_valid, count, ovf, drops} !== {1'b0, 5'd0, 1'b0, 8'd0}) begin n_fail++; $display("FAIL reset_status got %b %0d %b %0d want 0 0 0 0", m_valid, count, ovf, drops); end
    n_tests++; if ({m_addr, m_data, m_rw_n} !== 25'h0000001) begin n_fail++; $display("FAIL reset_head got %h %h %b want 0000 00 1", m_addr, m_data, m_rw_n); end
  endtask
  task automatic test_single_write();
    ready = 0;
    wr(16'hC030, 8'h5A, 0);
    n_tests++; if ({m_valid, count} !== {1'b1, 5'd1}) begin n_fail++; $display("FAIL single_status got valid=%b count=%0d want 1 1", m_valid, count); end
    n_tests++; if ({m_addr, m_data, m_rw_n} !== {16'hC030, 8'h5A, 1'b0}) begin n_fail++; $display("FAIL single_head got %h %h %b want c030 5a 0", m_addr, m_data, m_rw_n); end
    cyc();
    n_tests++; if ({m_valid, m_addr} !== {1'b1, 16'hC030}) begin n_fail++; $display("FAIL single_hold got %b %h want 1 c030", m_valid, m_addr); end
    ready = 1; cyc(); ready = 0;
    n_tests++; if ({m_valid, count} !== {1'b0, 5'd0}) begin n_fail++; $display("FAIL single_pop got %b %0d want 0 0", m_valid, count); end
  endtask
  task automatic test_window();
    wr(16'hBFFF, 8'h01, 0);
    wr(16'hC100, 8'h02, 0);
    wr(16'hC0FF, 8'h03, 0);
    wr(16'hC050, 8'h04, 1);
    en = 0; wr(16'hC010, 8'h05, 0); en = 1;
    n_tests++; if (count !== 5'd1) begin n_fail++; $display("FAIL window_count got %0d want 1", count); end
    n_tests++; if ({m_addr, m_data} !== {16'hC0FF, 8'h03}) begin n_fail++; $display("FAIL window_head got %h %h want c0ff 03", m_addr, m_data); end
    n_tests++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL window_disabled_drop got %b want 0", ovf); end
    drain();
  endtask
  task automatic test_overflow();
    for (int i = 0; i < 17; i++) wr(16'hC000 + 16'(i), 8'(i), 0);
    n_tests++; if ({count, ovf, drops} !== {5'd16, 1'b1, 8'd1}) begin n_fail++; $display("FAIL overflow_status got %0d %b %0d want 16 1 1", count, ovf, drops); end
    ready = 1;
    for (int i = 0; i < 16; i++) begin
      n_tests++; if ({m_valid, m_addr, m_data} !== {1'b1, 16'hC000 + 16'(i), 8'(i)}) begin n_fail++; $display("FAIL overflow_order[%0d] got %b %h %h want 1 %h %h", i, m_valid, m_addr, m_data, 16'hC000 + 16'(i), 8'(i)); end
      cyc();
    end
    ready = 0;
    n_tests++; if ({m_valid, count} !== {1'b0, 5'd0}) begin n_fail++; $display("FAIL overflow_empty got %b %0d want 0 0", m_valid, count); end
  endtask
  task automatic test_full_pop();
    clr = 1; cyc(); clr = 0;
    for (int i = 0; i < 16; i++) wr(16'hC080 + 16'(i), 8'h80 + 8'(i), 0);
    ready = 1;
    wr(16'hC0AA, 8'hAA, 0);
    n_tests++; if ({count, ovf, drops} !== {5'd16, 1'b0, 8'd0}) begin n_fail++; $display("FAIL fullpop_status got %0d %b %0d want 16 0 0", count, ovf, drops); end
    for (int i = 1; i < 17; i++) begin
      n_tests++; if (m_addr !== (i == 16 ? 16'hC0AA : 16'hC080 + 16'(i))) begin n_fail++; $display("FAIL fullpop_order[%0d] got %h want %h", i, m_addr, i == 16 ? 16'hC0AA : 16'hC080 + 16'(i)); end
      cyc();
    end
    ready = 0;
    n_tests++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL fullpop_empty got %b want 0", m_valid); end
  endtask
  task automatic test_drop_saturate();
    for (int i = 0; i < 316; i++) wr(16'hC000 + 16'(i[7:0]), 8'(i), 0);
    n_tests++; if ({count, ovf, drops} !== {5'd16, 1'b1, 8'd255}) begin n_fail++; $display("FAIL sat_status got %0d %b %0d want 16 1 255", count, ovf, drops); end
    clr = 1; wr(16'hC0EE, 8'hEE, 0); clr = 0;
    n_tests++; if ({ovf, drops} !== {1'b1, 8'd1}) begin n_fail++; $display("FAIL clear_vs_drop got %b %0d want 1 1", ovf, drops); end
    clr = 1; cyc(); clr = 0;
    n_tests++; if ({ovf, drops} !== {1'b0, 8'd0}) begin n_fail++; $display("FAIL clear got %b %0d want 0 0", ovf, drops); end
    drain();
  endtask
  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) wr(16'hC040 + 16'(i), 8'(i), 0);
    rst = 1; ready = 1; addr = 16'hC010; data = 8'h77; rw_n = 0; strobe = 1;
    cyc();
    rst = 0; ready = 0; strobe = 0;
    n_tests++; if ({m_valid, count, m_addr, m_data, m_rw_n} !== {1'b0, 5'd0, 16'h0000, 8'h00, 1'b1}) begin n_fail++; $display("FAIL midreset got %b %0d %h %h %b want 0 0 0000 00 1", m_valid, count, m_addr, m_data, m_rw_n); end
    wr(16'hC022, 8'h33, 0);
    n_tests++; if ({m_valid, count, m_addr, m_data} !== {1'b1, 5'd1, 16'hC022, 8'h33}) begin n_fail++; $display("FAIL midreset_fresh got %b %0d %h %h want 1 1 c022 33", m_valid, count, m_addr, m_data); end
    drain();
  endtask
  task automatic test_random();
    logic [15:0] edges [6] = '{16'hBFFF, 16'hC000, 16'hC001, 16'hC0FE, 16'hC0FF, 16'hC100};
    for (int n = 0; n < 3000; n++) begin
      strobe = $urandom_range(0, 2) != 0;
      case ($urandom_range(0, 2))
        0: addr = edges[$urandom_range(0, 5)];
        1: addr = 16'hC000 + 16'($urandom_range(0, 255));
        default: addr = 16'($urandom);
      endcase
      data  = 8'($urandom);
      rw_n  = $urandom_range(0, 3) == 0;
      en    = $urandom_range(0, 7) != 0;
      ready = $urandom_range(0, 2) == 0;
      clr   = $urandom_range(0, 40) == 0;
      rst   = $urandom_range(0, 400) == 0;
      cyc();
      n_tests++; if ({m_valid, count} !== {q.size() != 0, 5'(q.size())}) begin n_fail++; $display("FAIL rand_occupancy @%0d got %b %0d want %b %0d", n, m_valid, count, q.size() != 0, q.size()); end
      n_tests++; if ({ovf, drops} !== {mdl_ovf, 8'(mdl_drops)}) begin n_fail++; $display("FAIL rand_drops @%0d got %b %0d want %b %0d", n, ovf, drops, mdl_ovf, mdl_drops); end
      if (q.size() != 0) begin
        n_tests++; if ({m_addr, m_data, m_rw_n} !== q[0]) begin n_fail++; $display("FAIL rand_head @%0d got %h want %h", n, {m_addr, m_data, m_rw_n}, q[0]); end
      end
    end
    rst = 0; clr = 0; en = 1; strobe = 0;
    drain();
  endtask
  initial begin
    test_reset();
    test_single_write();
    test_window();
    test_overflow();
    test_full_pop();
    test_drop_saturate();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
